// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the round-robin Wishbone arbiter
package wb_arb_pkg;
  localparam int MAX_MASTERS = 8;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/wb_arb_rr_picker.sv
// wb_arb_rr_picker: rotate-priority encoder, first requester after ptr wins
module wb_arb_rr_picker #(
  parameter int N = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          valid
);
  logic [PW-1:0] j;
  // Scan from farthest to nearest so the nearest requester after ptr overwrites the rest
  always_comb begin
    win = '0;
    win_idx = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        win = '0;
        win[j] = 1'b1;
        win_idx = j;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone B4 arbiter, grant held for the whole cyc_i
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [31:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);
  localparam int N = NUM_MASTERS;
  localparam int PW = $clog2(N);
  arb_state_e state, state_n;
  logic [N-1:0] grant_n, win;
  logic [PW-1:0] ptr, ptr_n, win_idx;
  logic valid, g_cyc, g_stb, resp, timeout;
  wb_arb_rr_picker #(.N(N), .PW(PW)) u_picker (
    .req(wbm_cyc_i),
    .ptr(ptr),
    .win(win),
    .win_idx(win_idx),
    .valid(valid)
  );
  // Grant is one-hot or zero, so the slave-side mux collapses to 0 when idle
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_o[k]) begin
        wbs_adr_o = wbm_adr_i[k*32 +: 32];
        wbs_dat_o = wbm_dat_i[k*32 +: 32];
        wbs_sel_o = wbm_sel_i[k*4 +: 4];
        wbs_we_o = wbm_we_i[k];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
        g_cyc = wbm_cyc_i[k];
        g_stb = wbm_stb_i[k];
      end
    end
  end
  assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wbs_cyc_o = g_cyc & ~timeout;
  assign wbs_stb_o = g_stb & ~timeout;
  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = grant_o & {N{wbs_ack_i}};
  assign wbm_err_o = grant_o & {N{wbs_err_i | timeout}};
  assign wbm_rty_o = grant_o & {N{wbs_rty_i}};
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] cnt;
  assign timeout = (state == ARB_BUSY) && g_stb && !resp && (cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt <= '0;
    else if (state == ARB_IDLE || timeout || resp || !g_cyc) cnt <= '0;
    else if (g_stb) cnt <= cnt + 1'b1;
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ARB_IDLE;
      grant_o <= '0;
      ptr <= PW'(N - 1);
    end else begin
      state <= state_n;
      grant_o <= grant_n;
      ptr <= ptr_n;
    end
  end
  // Leaving BUSY always passes through IDLE, giving the one dead cycle between grants
  always_comb begin
    state_n = state;
    grant_n = grant_o;
    ptr_n = ptr;
    if (state == ARB_IDLE) begin
      if (valid) begin
        state_n = ARB_BUSY;
        grant_n = win;
        ptr_n = win_idx;
      end
    end else if (!g_cyc || timeout) begin
      state_n = ARB_IDLE;
      grant_n = '0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: directed and random checks of wb_arbiter_rr against an index-based reference model
module tb_wb_arbiter_rr;
  localparam int NM = 3;
  localparam int TO = 16;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [NM*32-1:0] adr_bus, dat_bus;
  logic [NM*4-1:0] sel_bus;
  logic [NM*3-1:0] cti_bus;
  logic [NM*2-1:0] bte_bus;
  logic [NM-1:0] m_we, m_cyc, m_stb;
  logic [31:0] m_adr[NM], m_dat[NM];
  logic [3:0] m_sel[NM];
  logic [2:0] m_cti[NM];
  logic [1:0] m_bte[NM];
  logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, s_dat;
  logic [NM-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [3:0] wbs_sel_o;
  logic wbs_we_o, wbs_cyc_o, wbs_stb_o, s_ack, s_err, s_rty;
  logic [2:0] wbs_cti_o;
  logic [1:0] wbs_bte_o;
  int total = 0, bad = 0;
  int mg, last, stall;
  int served[NM];
  logic [NM-1:0] prev_grant, last_resp;
  always #5 wb_clk_i = ~wb_clk_i;
  always_comb begin
    for (int k = 0; k < NM; k++) begin
      adr_bus[k*32 +: 32] = m_adr[k];
      dat_bus[k*32 +: 32] = m_dat[k];
      sel_bus[k*4 +: 4] = m_sel[k];
      cti_bus[k*3 +: 3] = m_cti[k];
      bte_bus[k*2 +: 2] = m_bte[k];
    end
  end
  wb_arbiter_rr #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(adr_bus), .wbm_dat_i(dat_bus), .wbm_sel_i(sel_bus),
    .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(cti_bus), .wbm_bte_i(bte_bus),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_inputs();
    m_we = '0; m_cyc = '0; m_stb = '0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0;
    for (int k = 0; k < NM; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0; m_cti[k] = '0; m_bte[k] = '0;
    end
  endtask
  task automatic model_reset();
    mg = -1; last = NM - 1; stall = 0; prev_grant = '0; last_resp = '0;
  endtask
  task automatic mreq(input int k, input logic c, input logic [31:0] a, input logic w, input logic [2:0] ct);
    m_cyc[k] = c; m_stb[k] = c; m_adr[k] = a; m_we[k] = w; m_cti[k] = ct;
    m_sel[k] = 4'hf; m_dat[k] = a ^ 32'h5a5a_5a5a; m_bte[k] = 2'b00;
  endtask
  task automatic do_reset();
    wb_rst_i = 1'b1;
    clear_inputs();
    #1;
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_cyc", 64'(wbs_cyc_o), 64'(0));
    check("rst_stb", 64'(wbs_stb_o), 64'(0));
    check("rst_adr", 64'(wbs_adr_o), 64'(0));
    check("rst_ack", 64'(wbm_ack_o), 64'(0));
    model_reset();
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
  endtask
  // One bus cycle: compare all outputs to the model, then advance the model on the edge
  task automatic tick();
    logic to_m, rsp, act;
    logic [NM-1:0] eg;
    int gi;
    #1;
    rsp = s_ack | s_err | s_rty;
    act = mg >= 0;
    gi = act ? mg : 0;
    eg = '0;
    if (act) eg[gi] = 1'b1;
    to_m = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    to_m = act && m_stb[gi] && !rsp && (stall == TO - 1);
`endif
    check("grant", 64'(grant_o), 64'(eg));
    check("cyc", 64'(wbs_cyc_o), 64'(act && m_cyc[gi] && !to_m));
    check("stb", 64'(wbs_stb_o), 64'(act && m_stb[gi] && !to_m));
    check("adr", 64'(wbs_adr_o), 64'(act ? m_adr[gi] : 32'h0));
    check("wdat", 64'(wbs_dat_o), 64'(act ? m_dat[gi] : 32'h0));
    check("sel", 64'(wbs_sel_o), 64'(act ? m_sel[gi] : 4'h0));
    check("we", 64'(wbs_we_o), 64'(act && m_we[gi]));
    check("cti", 64'(wbs_cti_o), 64'(act ? m_cti[gi] : 3'h0));
    check("bte", 64'(wbs_bte_o), 64'(act ? m_bte[gi] : 2'h0));
    check("ack", 64'(wbm_ack_o), 64'(eg & {NM{s_ack}}));
    check("err", 64'(wbm_err_o), 64'(eg & {NM{s_err | to_m}}));
    check("rty", 64'(wbm_rty_o), 64'(eg & {NM{s_rty}}));
    check("rdat", 64'(wbm_dat_o), 64'(s_dat));
    last_resp = wbm_ack_o | wbm_err_o | wbm_rty_o;
    if (prev_grant == '0)
      for (int k = 0; k < NM; k++) if (grant_o[k]) served[k]++;
    prev_grant = grant_o;
    @(posedge wb_clk_i);
    if (mg < 0) begin
      if (|m_cyc) begin
        for (int i = 1; i <= NM; i++) begin
          if (mg < 0 && m_cyc[(last + i) % NM]) mg = (last + i) % NM;
        end
        last = mg;
        stall = 0;
      end
    end else if (!m_cyc[mg] || to_m) begin
      mg = -1;
      stall = 0;
    end else if (rsp) stall = 0;
    else if (m_stb[mg]) stall++;
    #1;
  endtask
  initial begin
    for (int k = 0; k < NM; k++) served[k] = 0;
    do_reset();
    // single read from M0, slave acks on the third busy cycle
    mreq(0, 1, 32'h0000_1000, 0, 3'b000);
    tick();
    check("t1_grant", 64'(grant_o), 64'(1));
    check("t1_adr", 64'(wbs_adr_o), 64'(32'h1000));
    tick();
    tick();
    s_ack = 1; s_dat = 32'hcafe_0001;
    #1;
    check("t1_ack", 64'(wbm_ack_o), 64'(1));
    tick();
    s_ack = 0;
    mreq(0, 0, 32'h0, 0, 3'b000);
    tick();
    check("t1_idle", 64'(grant_o), 64'(0));
    // simultaneous requests from reset
    do_reset();
    mreq(0, 1, 32'h100, 0, 3'b000);
    mreq(1, 1, 32'h200, 1, 3'b000);
    tick();
    check("t2_first", 64'(grant_o), 64'(1));
    s_ack = 1;
    tick();
    s_ack = 0;
    mreq(0, 0, 32'h0, 0, 3'b000);
    tick();
    check("t2_gap", 64'(grant_o), 64'(0));
    tick();
    check("t2_second", 64'(grant_o), 64'(2));
    // both masters re-request continuously, 4 busy cycles each
    do_reset();
    mreq(0, 1, 32'h300, 0, 3'b000);
    mreq(1, 1, 32'h400, 0, 3'b000);
    tick();
    for (int r = 0; r < 4; r++) begin
      check($sformatf("t3_rr%0d", r), 64'(grant_o), 64'(r % 2 == 0 ? 1 : 2));
      repeat (3) tick();
      m_cyc[r % 2] = 0;
      tick();
      m_cyc[r % 2] = 1;
      tick();
    end
    // M1 incrementing burst holds the grant while M0 waits
    do_reset();
    mreq(1, 1, 32'h2000, 0, 3'b010);
    tick();
    mreq(0, 1, 32'h3000, 0, 3'b000);
    for (int b = 0; b < 4; b++) begin
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      m_adr[1] = 32'h2000 + 32'(b * 4);
      s_ack = 1;
      #1;
      check("t4_grant", 64'(grant_o), 64'(2));
      check("t4_ack0", 64'(wbm_ack_o[0]), 64'(0));
      check("t4_ack1", 64'(wbm_ack_o[1]), 64'(1));
      tick();
    end
    s_ack = 0;
    mreq(1, 0, 32'h0, 0, 3'b000);
    tick();
    tick();
    check("t4_m0", 64'(grant_o), 64'(1));
    mreq(0, 0, 32'h0, 0, 3'b000);
    tick();
    // slave error on an M1 write
    do_reset();
    mreq(1, 1, 32'h4000, 1, 3'b000);
    tick();
    s_err = 1;
    #1;
    check("t5_err", 64'(wbm_err_o), 64'(2));
    check("t5_err0", 64'(wbm_err_o[0]), 64'(0));
    tick();
    s_err = 0;
    mreq(1, 0, 32'h0, 0, 3'b000);
    tick();
    // slave never responds
    do_reset();
    mreq(0, 1, 32'h5000, 0, 3'b000);
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("t6_to_err", 64'(wbm_err_o), 64'(1));
    check("t6_to_cyc", 64'(wbs_cyc_o), 64'(0));
    tick();
    check("t6_to_grant", 64'(grant_o), 64'(0));
    check("t6_to_cyc2", 64'(wbs_cyc_o), 64'(0));
`else
    repeat (20) tick();
    check("t6_hang_stb", 64'(wbs_stb_o), 64'(1));
    check("t6_hang_grant", 64'(grant_o), 64'(1));
`endif
    mreq(0, 0, 32'h0, 0, 3'b000);
    tick();
    // reset asserted in the middle of a granted cycle
    mreq(2, 1, 32'h6000, 0, 3'b000);
    tick();
    tick();
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("t7_grant", 64'(grant_o), 64'(0));
    check("t7_cyc", 64'(wbs_cyc_o), 64'(0));
    check("t7_stb", 64'(wbs_stb_o), 64'(0));
    clear_inputs();
    model_reset();
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    for (int k = 0; k < NM; k++) served[k] = 0;
    // random traffic: masters hold cyc until answered, may withdraw while waiting
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NM; k++) begin
        if (m_cyc[k]) begin
          if (last_resp[k]) begin
            if ($urandom_range(1, 0) == 1) begin
              m_cyc[k] = 0; m_stb[k] = 0;
            end else begin
              m_adr[k] = $urandom; m_dat[k] = $urandom;
              m_cti[k] = ($urandom_range(1, 0) == 1) ? 3'b010 : 3'b111;
            end
          end else if (!grant_o[k] && $urandom_range(19, 0) == 0) begin
            m_cyc[k] = 0; m_stb[k] = 0;
          end else m_stb[k] = $urandom_range(3, 0) != 0;
        end else if ($urandom_range(2, 0) == 0) begin
          m_cyc[k] = 1; m_stb[k] = 1; m_we[k] = 1'($urandom);
          m_adr[k] = $urandom; m_dat[k] = $urandom; m_sel[k] = 4'($urandom);
          m_cti[k] = 3'($urandom); m_bte[k] = 2'($urandom);
        end
      end
      s_ack = $urandom_range(2, 0) == 0;
      s_err = $urandom_range(15, 0) == 0;
      s_rty = $urandom_range(15, 0) == 0;
      s_dat = $urandom;
      tick();
    end
    for (int k = 0; k < NM; k++) check($sformatf("served%0d", k), 64'(served[k] > 0), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
